spi_periph_sync: RTL and testbench

Oversampled SPI peripheral for the digital core. It synchronises SCK, CS and PICO into the system clock domain and detects SCK edges there. Word width, command-field width and SPI mode (CPOL/CPHA) are parameters. It adds a valid/ready transmit handshake, back-to-back multi-word frames, and underrun and abort reporting. It sits between the pad ring and the register file.

---
 rtl/spi_periph_sync.sv | 208 ++++++++++++++++++++
 tb/tb_spi_periph_sync.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_periph_sync.sv
// Oversampled SPI peripheral: SCK/CS/PICO are synchronised into CLK and edges
// are detected there; valid/ready transmit holding register, multi-word frames.
module spi_periph_sync #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned CMD_W  = 8,
  parameter bit          CPOL   = 1'b0,
  parameter bit          CPHA   = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SCK,
  input  logic              CS,
  input  logic              PICO,
  output logic              POCI,
  output logic              POCI_OE,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [CMD_W-1:0]  cmd_byte,
  output logic              cmd_valid,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_active,
  output logic              tx_underrun,
  output logic              frame_abort
);

  localparam int unsigned CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CMD_BIT  = CNT_W'(CMD_W - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  logic sck_s1_q, sck_s2_q, sck_d_q;
  logic cs_s1_q, cs_s2_q, cs_d_q;
  logic pico_s1_q, pico_s2_q, pico_d_q;

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [WORD_W-2:0] shift_in_q, shift_in_d;
  logic [WORD_W-1:0] shift_out_q, shift_out_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              full_q, full_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic              cmd_v_q, cmd_v_d;
  logic [WORD_W-1:0] rx_q, rx_d;
  logic              rx_v_q, rx_v_d;
  logic              und_q, und_d;
  logic              und_pend_q, und_pend_d;
  logic              abort_q, abort_d;

  logic              lead_ev, trail_ev, sample_ev, shift_ev;
  logic              cs_fall, cs_rise, load;
  logic [WORD_W-1:0] shift_in_nxt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sck_s1_q  <= CPOL;
      sck_s2_q  <= CPOL;
      sck_d_q   <= CPOL;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_d_q    <= 1'b1;
      pico_s1_q <= 1'b0;
      pico_s2_q <= 1'b0;
      pico_d_q  <= 1'b0;
    end else begin
      sck_s1_q  <= SCK;
      sck_s2_q  <= sck_s1_q;
      sck_d_q   <= sck_s2_q;
      cs_s1_q   <= CS;
      cs_s2_q   <= cs_s1_q;
      cs_d_q    <= cs_s2_q;
      pico_s1_q <= PICO;
      pico_s2_q <= pico_s1_q;
      pico_d_q  <= pico_s2_q;
    end
  end

  assign lead_ev   = (sck_s2_q != CPOL) && (sck_d_q == CPOL);
  assign trail_ev  = (sck_s2_q == CPOL) && (sck_d_q != CPOL);
  assign sample_ev = CPHA ? trail_ev : lead_ev;
  assign shift_ev  = CPHA ? lead_ev : trail_ev;
  assign cs_fall   = !cs_s2_q && cs_d_q;
  assign cs_rise   = cs_s2_q && !cs_d_q;

  assign shift_in_nxt = {shift_in_q, pico_d_q};

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    hold_d      = hold_q;
    full_d      = full_q;
    cmd_d       = cmd_q;
    rx_d        = rx_q;
    und_pend_d  = und_pend_q;
    cmd_v_d     = 1'b0;
    rx_v_d      = 1'b0;
    und_d       = 1'b0;
    abort_d     = 1'b0;
    load        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bitcnt_d   = '0;
        und_pend_d = 1'b0;
        if (cs_fall) begin
          state_d = ST_XFER;
          load    = !CPHA;
        end
      end
      default: begin
        if (cs_rise) begin
          state_d    = ST_IDLE;
          bitcnt_d   = '0;
          und_pend_d = 1'b0;
          abort_d    = (bitcnt_q != '0);
        end else if (sample_ev) begin
          shift_in_d = shift_in_nxt[WORD_W-2:0];
          bitcnt_d   = (bitcnt_q == LAST_BIT) ? '0 : bitcnt_q + CNT_W'(1);
          // An empty load is reported when its word's first bit is taken, so
          // the CPHA=0 look-ahead load at the end of a frame stays silent.
          if (bitcnt_q == '0) begin
            und_d      = und_pend_q;
            und_pend_d = 1'b0;
          end
          if (bitcnt_q == CMD_BIT) begin
            cmd_d   = shift_in_nxt[CMD_W-1:0];
            cmd_v_d = 1'b1;
          end
          if (bitcnt_q == LAST_BIT) begin
            rx_d   = shift_in_nxt;
            rx_v_d = 1'b1;
            load   = !CPHA;
          end
        end else if (shift_ev) begin
          if (bitcnt_q == '0) begin
            load = CPHA;
          end else begin
            shift_out_d = shift_out_q << 1;
          end
        end
      end
    endcase

    if (load) begin
      if (full_q) begin
        shift_out_d = hold_q;
        full_d      = 1'b0;
      end else begin
        shift_out_d = '0;
        und_pend_d  = 1'b1;
      end
    end

    if (tx_valid && !full_q) begin
      hold_d = tx_data;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      hold_q      <= '0;
      full_q      <= 1'b0;
      cmd_q       <= '0;
      cmd_v_q     <= 1'b0;
      rx_q        <= '0;
      rx_v_q      <= 1'b0;
      und_q       <= 1'b0;
      und_pend_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      hold_q      <= hold_d;
      full_q      <= full_d;
      cmd_q       <= cmd_d;
      cmd_v_q     <= cmd_v_d;
      rx_q        <= rx_d;
      rx_v_q      <= rx_v_d;
      und_q       <= und_d;
      und_pend_q  <= und_pend_d;
      abort_q     <= abort_d;
    end
  end

  assign frame_active = (state_q == ST_XFER);
  assign POCI_OE      = frame_active;
  assign POCI         = POCI_OE & shift_out_q[WORD_W-1];
  assign tx_ready     = !full_q;
  assign cmd_byte     = cmd_q;
  assign cmd_valid    = cmd_v_q;
  assign rx_data      = rx_q;
  assign rx_valid     = rx_v_q;
  assign tx_underrun  = und_q;
  assign frame_abort  = abort_q;

endmodule

// File: tb/tb_spi_periph_sync.sv
// Directed bench for spi_periph_sync: mode 0 and mode 3 instances driven by a
// behavioural SPI controller with hand-computed expected words.
module tb_spi_periph_sync;

  logic        CLK = 1'b0;
  logic        RST;
  logic        PICO;
  logic        sck0, cs0, sck3, cs3;
  logic [15:0] txd0, txd3;
  logic        txv0, txv3;

  logic        poci0, oe0, txr0, cmdv0, rxv0, fa0, und0, ab0;
  logic [7:0]  cmd0;
  logic [15:0] rxd0;
  logic        poci3, oe3, txr3, cmdv3, rxv3, fa3, und3, ab3;
  logic [7:0]  cmd3;
  logic [15:0] rxd3;

  int checks = 0;
  int errors = 0;
  int rx_cnt0 = 0, cmd_cnt0 = 0, und_cnt0 = 0, ab_cnt0 = 0;
  int rx_cnt3 = 0, und_cnt3 = 0, ab_cnt3 = 0;
  logic [15:0] rx_log0 [0:7];

  always #5 CLK = ~CLK;

  spi_periph_sync #(.WORD_W(16), .CMD_W(8), .CPOL(1'b0), .CPHA(1'b0)) u0 (
    .CLK(CLK), .RST(RST), .SCK(sck0), .CS(cs0), .PICO(PICO),
    .POCI(poci0), .POCI_OE(oe0), .tx_data(txd0), .tx_valid(txv0),
    .tx_ready(txr0), .cmd_byte(cmd0), .cmd_valid(cmdv0), .rx_data(rxd0),
    .rx_valid(rxv0), .frame_active(fa0), .tx_underrun(und0), .frame_abort(ab0)
  );

  spi_periph_sync #(.WORD_W(16), .CMD_W(8), .CPOL(1'b1), .CPHA(1'b1)) u3 (
    .CLK(CLK), .RST(RST), .SCK(sck3), .CS(cs3), .PICO(PICO),
    .POCI(poci3), .POCI_OE(oe3), .tx_data(txd3), .tx_valid(txv3),
    .tx_ready(txr3), .cmd_byte(cmd3), .cmd_valid(cmdv3), .rx_data(rxd3),
    .rx_valid(rxv3), .frame_active(fa3), .tx_underrun(und3), .frame_abort(ab3)
  );

  always @(negedge CLK) begin
    if (rxv0) begin
      rx_log0[rx_cnt0 % 8] = rxd0;
      rx_cnt0++;
    end
    if (cmdv0) cmd_cnt0++;
    if (und0)  und_cnt0++;
    if (ab0)   ab_cnt0++;
    if (rxv3)  rx_cnt3++;
    if (und3)  und_cnt3++;
    if (ab3)   ab_cnt3++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1 ms");
    $fatal(1);
  end

  task automatic spi_bits(input bit m3, input logic [15:0] data, input int n,
                          output logic [15:0] miso);
    miso = '0;
    for (int i = 0; i < n; i++) begin
      if (!m3) begin
        PICO = data[15];
        #80;
        miso = {miso[14:0], poci0};
        sck0 = 1'b1;
        #80;
        sck0 = 1'b0;
      end else begin
        sck3 = 1'b0;
        PICO = data[15];
        #80;
        miso = {miso[14:0], poci3};
        sck3 = 1'b1;
        #80;
      end
      data = data << 1;
    end
  endtask

  task automatic frame_start(input bit m3);
    @(posedge CLK); #1;
    if (m3) cs3 = 1'b0; else cs0 = 1'b0;
    #80;
  endtask

  task automatic frame_end(input bit m3);
    #80;
    if (m3) cs3 = 1'b1; else cs0 = 1'b1;
    #160;
  endtask

  task automatic tx_write(input bit m3, input logic [15:0] d);
    int k;
    k = 0;
    @(posedge CLK); #1;
    while (((m3 ? txr3 : txr0) !== 1'b1) && k < 100) begin
      @(posedge CLK); #1;
      k++;
    end
    checks++;
    if (k >= 100) begin
      errors++;
      $display("FAIL tx_write_timeout: tx_ready=0 required=1");
    end
    if (m3) begin txd3 = d; txv3 = 1'b1; end
    else    begin txd0 = d; txv0 = 1'b1; end
    @(posedge CLK); #1;
    txv0 = 1'b0;
    txv3 = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    checks++;
    if ({poci0, oe0, txr0, cmdv0, rxv0, fa0, und0, ab0} !== 8'b0010_0000) begin
      errors++;
      $display("FAIL reset_flags0: got %b required 00100000",
               {poci0, oe0, txr0, cmdv0, rxv0, fa0, und0, ab0});
    end
    checks++;
    if ({cmd0, rxd0} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data0: got cmd=%h rx=%h required 00/0000", cmd0, rxd0);
    end
    checks++;
    if ({poci3, oe3, txr3, fa3} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_flags3: got %b required 0010", {poci3, oe3, txr3, fa3});
    end
    RST = 1'b0;
    repeat (4) @(posedge CLK);
  endtask

  task automatic test_mode0_basic();
    logic [15:0] r1, r2;
    int rc, cc, uc, ac;
    rc = rx_cnt0; cc = cmd_cnt0; uc = und_cnt0; ac = ab_cnt0;
    tx_write(0, 16'h1234);
    checks++;
    if (txr0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_full: tx_ready=%b required 0", txr0);
    end
    frame_start(0);
    checks++;
    if ({fa0, oe0, txr0} !== 3'b111) begin
      errors++;
      $display("FAIL basic_active: fa/oe/ready=%b required 111", {fa0, oe0, txr0});
    end
    spi_bits(0, 16'hA55A, 8, r1);
    checks++;
    if (cmd0 !== 8'hA5 || cmd_cnt0 - cc != 1 || rx_cnt0 != rc) begin
      errors++;
      $display("FAIL basic_cmd: cmd=%h pulses=%0d rx=%0d required A5/1/0",
               cmd0, cmd_cnt0 - cc, rx_cnt0 - rc);
    end
    spi_bits(0, 16'h5A00, 8, r2);
    frame_end(0);
    checks++;
    if (rxd0 !== 16'hA55A || rx_cnt0 - rc != 1) begin
      errors++;
      $display("FAIL basic_rx: rx=%h pulses=%0d required A55A/1", rxd0, rx_cnt0 - rc);
    end
    checks++;
    if ({r1[7:0], r2[7:0]} !== 16'h1234) begin
      errors++;
      $display("FAIL basic_poci: got %h required 1234", {r1[7:0], r2[7:0]});
    end
    checks++;
    if (und_cnt0 != uc || ab_cnt0 != ac || fa0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_clean: und=%0d abort=%0d fa=%b required 0/0/0",
               und_cnt0 - uc, ab_cnt0 - ac, fa0);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b, c;
    int rc, uc;
    rc = rx_cnt0; uc = und_cnt0;
    tx_write(0, 16'hBEEF);
    frame_start(0);
    spi_bits(0, 16'h0001, 8, a);
    tx_write(0, 16'hCAFE);
    spi_bits(0, 16'h0100, 8, b);
    spi_bits(0, 16'hFFFF, 16, c);
    frame_end(0);
    checks++;
    if (rx_cnt0 - rc != 2) begin
      errors++;
      $display("FAIL b2b_count: rx pulses=%0d required 2", rx_cnt0 - rc);
    end
    checks++;
    if (rx_log0[rc % 8] !== 16'h0001 || rx_log0[(rc + 1) % 8] !== 16'hFFFF) begin
      errors++;
      $display("FAIL b2b_rx: got %h %h required 0001 FFFF",
               rx_log0[rc % 8], rx_log0[(rc + 1) % 8]);
    end
    checks++;
    if ({a[7:0], b[7:0]} !== 16'hBEEF || c !== 16'hCAFE) begin
      errors++;
      $display("FAIL b2b_poci: got %h %h required BEEF CAFE", {a[7:0], b[7:0]}, c);
    end
    checks++;
    if (und_cnt0 != uc) begin
      errors++;
      $display("FAIL b2b_underrun: pulses=%0d required 0", und_cnt0 - uc);
    end
  endtask

  task automatic test_underrun();
    logic [15:0] m;
    int rc, uc;
    rc = rx_cnt0; uc = und_cnt0;
    frame_start(0);
    spi_bits(0, 16'h3C3C, 16, m);
    frame_end(0);
    checks++;
    if (und_cnt0 - uc != 1) begin
      errors++;
      $display("FAIL underrun_pulse: pulses=%0d required 1", und_cnt0 - uc);
    end
    checks++;
    if (m !== 16'h0000) begin
      errors++;
      $display("FAIL underrun_poci: got %h required 0000", m);
    end
    checks++;
    if (rxd0 !== 16'h3C3C || rx_cnt0 - rc != 1 || cmd0 !== 8'h3C) begin
      errors++;
      $display("FAIL underrun_rx: rx=%h pulses=%0d cmd=%h required 3C3C/1/3C",
               rxd0, rx_cnt0 - rc, cmd0);
    end
  endtask

  task automatic test_abort();
    logic [15:0] m;
    int rc, ac;
    rc = rx_cnt0; ac = ab_cnt0;
    frame_start(0);
    spi_bits(0, 16'hF800, 5, m);
    frame_end(0);
    checks++;
    if (ab_cnt0 - ac != 1 || rx_cnt0 != rc) begin
      errors++;
      $display("FAIL abort_pulse: abort=%0d rx=%0d required 1/0", ab_cnt0 - ac, rx_cnt0 - rc);
    end
    checks++;
    if (fa0 !== 1'b0 || u0.bitcnt_q !== 4'd0 || cmd0 !== 8'h3C) begin
      errors++;
      $display("FAIL abort_state: fa=%b bitcnt=%0d cmd=%h required 0/0/3C",
               fa0, u0.bitcnt_q, cmd0);
    end
    rc = rx_cnt0;
    tx_write(0, 16'h0F0F);
    frame_start(0);
    spi_bits(0, 16'h1357, 16, m);
    frame_end(0);
    checks++;
    if (rxd0 !== 16'h1357 || rx_cnt0 - rc != 1 || m !== 16'h0F0F) begin
      errors++;
      $display("FAIL abort_recover: rx=%h pulses=%0d poci=%h required 1357/1/0F0F",
               rxd0, rx_cnt0 - rc, m);
    end
  endtask

  task automatic test_mode3();
    logic [15:0] m;
    int rc, uc, ac;
    rc = rx_cnt3; uc = und_cnt3; ac = ab_cnt3;
    tx_write(1, 16'h8001);
    frame_start(1);
    spi_bits(1, 16'h5AA5, 16, m);
    frame_end(1);
    checks++;
    if (rxd3 !== 16'h5AA5 || rx_cnt3 - rc != 1) begin
      errors++;
      $display("FAIL mode3_rx: rx=%h pulses=%0d required 5AA5/1", rxd3, rx_cnt3 - rc);
    end
    checks++;
    if (m !== 16'h8001) begin
      errors++;
      $display("FAIL mode3_poci: got %h required 8001", m);
    end
    checks++;
    if (cmd3 !== 8'h5A || und_cnt3 != uc || ab_cnt3 != ac) begin
      errors++;
      $display("FAIL mode3_misc: cmd=%h und=%0d abort=%0d required 5A/0/0",
               cmd3, und_cnt3 - uc, ab_cnt3 - ac);
    end
  endtask

  task automatic test_reset_midword();
    logic [15:0] m;
    int ac;
    ac = ab_cnt0;
    tx_write(0, 16'hAAAA);
    frame_start(0);
    spi_bits(0, 16'hFFFF, 5, m);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if ({poci0, oe0, txr0, cmdv0, rxv0, fa0, und0, ab0} !== 8'b0010_0000) begin
      errors++;
      $display("FAIL rst_mid_flags: got %b required 00100000",
               {poci0, oe0, txr0, cmdv0, rxv0, fa0, und0, ab0});
    end
    checks++;
    if (cmd0 !== 8'h00 || rxd0 !== 16'h0000 || u0.bitcnt_q !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid_data: cmd=%h rx=%h bitcnt=%0d required 00/0000/0",
               cmd0, rxd0, u0.bitcnt_q);
    end
    cs0 = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (8) @(posedge CLK);
    #1;
    checks++;
    if (ab_cnt0 != ac || fa0 !== 1'b0 || txr0 !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_after: abort=%0d fa=%b ready=%b required 0/0/1",
               ab_cnt0 - ac, fa0, txr0);
    end
  endtask

  initial begin
    RST  = 1'b1;
    PICO = 1'b0;
    sck0 = 1'b0;
    cs0  = 1'b1;
    sck3 = 1'b1;
    cs3  = 1'b1;
    txd0 = '0;
    txd3 = '0;
    txv0 = 1'b0;
    txv3 = 1'b0;
    test_reset();
    test_mode0_basic();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_mode3();
    test_reset_midword();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
